// File: rtl/riscv_hazard.sv
// Stall, flush and forwarding control for the 5-stage RISC-V pipeline, with saturating perf counters.
// Optional feature macro: RISCV_HAZARD_FWD_EN (forwarding + load-use stall); undefined = stall on any RAW.
module riscv_hazard #(
    parameter int CNT_W = 16
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic [4:0]       irs1_d,
    input  logic [4:0]       irs2_d,
    input  logic [4:0]       ird_d,
    input  logic             iuses_rs1_d,
    input  logic             iuses_rs2_d,
    input  logic             ird_wr_en_d,
    input  logic             iload_d,
    input  logic             ipc_src_e,
    output logic             ostall_f,
    output logic             ostall_d,
    output logic             oflush_d,
    output logic             oflush_e,
    output logic [1:0]       oforward_a_e,
    output logic [1:0]       oforward_b_e,
    output logic [CNT_W-1:0] ostall_cnt,
    output logic [CNT_W-1:0] oflush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0]       rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             wr_en_e, load_e, wr_en_m, wr_en_w;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             hazard;
    logic [1:0]       fwd_a, fwd_b;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic en);
        return en && (src != 5'd0) && (src == dst);
    endfunction

`ifdef RISCV_HAZARD_FWD_EN
    always_comb begin
        hazard = load_e & ((iuses_rs1_d & src_match(irs1_d, rd_e, wr_en_e)) |
                           (iuses_rs2_d & src_match(irs2_d, rd_e, wr_en_e)));
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (src_match(rs1_e, rd_m, wr_en_m))      fwd_a = 2'b10;
        else if (src_match(rs1_e, rd_w, wr_en_w)) fwd_a = 2'b01;
        if (src_match(rs2_e, rd_m, wr_en_m))      fwd_b = 2'b10;
        else if (src_match(rs2_e, rd_w, wr_en_w)) fwd_b = 2'b01;
    end
`else
    // Without bypass paths every producer still in E or M must drain first; W is
    // covered by the register file's write-before-read.
    always_comb begin
        hazard = (iuses_rs1_d & (src_match(irs1_d, rd_e, wr_en_e) |
                                 src_match(irs1_d, rd_m, wr_en_m))) |
                 (iuses_rs2_d & (src_match(irs2_d, rd_e, wr_en_e) |
                                 src_match(irs2_d, rd_m, wr_en_m)));
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
    end

    logic unused_bits;
    assign unused_bits = ^{rs1_e, rs2_e, load_e, rd_w, wr_en_w};
`endif

    // A taken branch wins over a stall: the decode instruction is wrong-path.
    assign ostall_d     = ~irst & hazard & ~ipc_src_e;
    assign ostall_f     = ostall_d;
    assign oflush_d     = ~irst & ipc_src_e;
    assign oflush_e     = ~irst & (ipc_src_e | hazard);
    assign oforward_a_e = irst ? 2'b00 : fwd_a;
    assign oforward_b_e = irst ? 2'b00 : fwd_b;
    assign ostall_cnt   = irst ? '0 : stall_cnt;
    assign oflush_cnt   = irst ? '0 : flush_cnt;

    always_ff @(posedge iclk) begin
        if (irst) begin
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
            wr_en_e   <= 1'b0;
            load_e    <= 1'b0;
            rd_m      <= '0;
            wr_en_m   <= 1'b0;
            rd_w      <= '0;
            wr_en_w   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (oflush_e) begin
                rs1_e   <= '0;
                rs2_e   <= '0;
                rd_e    <= '0;
                wr_en_e <= 1'b0;
                load_e  <= 1'b0;
            end else begin
                rs1_e   <= irs1_d;
                rs2_e   <= irs2_d;
                rd_e    <= ird_d;
                wr_en_e <= ird_wr_en_d;
                load_e  <= iload_d;
            end
            rd_m    <= rd_e;
            wr_en_m <= wr_en_e;
            rd_w    <= rd_m;
            wr_en_w <= wr_en_m;
            if (ostall_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
            if (ipc_src_e && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_riscv_hazard.sv
// Randomized and directed bench for riscv_hazard against an instruction-level pipeline model.
// Honors RISCV_HAZARD_FWD_EN the same way the design does.
module tb_riscv_hazard;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       wr;
        logic       ld;
    } instr_t;

    logic             iclk = 1'b0;
    logic             irst = 1'b1;
    logic [4:0]       irs1_d = '0, irs2_d = '0, ird_d = '0;
    logic             iuses_rs1_d = 1'b0, iuses_rs2_d = 1'b0;
    logic             ird_wr_en_d = 1'b0, iload_d = 1'b0, ipc_src_e = 1'b0;
    logic             ostall_f, ostall_d, oflush_d, oflush_e;
    logic [1:0]       oforward_a_e, oforward_b_e;
    logic [CNT_W-1:0] ostall_cnt, oflush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: one instruction record per stage, plus counters.
    instr_t m_e = '0, m_m = '0, m_w = '0;
    int     m_scnt = 0, m_fcnt = 0;
    logic   last_stall = 1'b0;

    localparam instr_t IDLE = '0;

    riscv_hazard #(.CNT_W(CNT_W)) dut (
        .iclk(iclk), .irst(irst),
        .irs1_d(irs1_d), .irs2_d(irs2_d), .ird_d(ird_d),
        .iuses_rs1_d(iuses_rs1_d), .iuses_rs2_d(iuses_rs2_d),
        .ird_wr_en_d(ird_wr_en_d), .iload_d(iload_d), .ipc_src_e(ipc_src_e),
        .ostall_f(ostall_f), .ostall_d(ostall_d), .oflush_d(oflush_d), .oflush_e(oflush_e),
        .oforward_a_e(oforward_a_e), .oforward_b_e(oforward_b_e),
        .ostall_cnt(ostall_cnt), .oflush_cnt(oflush_cnt)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                  input bit u1, input bit u2, input bit wr, input bit ld);
        instr_t i;
        i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
        i.u1 = u1; i.u2 = u2; i.wr = wr; i.ld = ld;
        return i;
    endfunction

    // Does a reader of src depend on the instruction sitting in stage st?
    function automatic bit dep(input logic [4:0] src, input instr_t st);
        return st.wr && (src != 5'd0) && (src == st.rd);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
`ifdef RISCV_HAZARD_FWD_EN
        if (dep(src, m_m)) return 2'b10;
        if (dep(src, m_w)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    // One clock: drive D inputs, compare all outputs mid-cycle, then advance the model.
    task automatic step(input instr_t d, input logic pc, input logic rst);
        bit raw, e_stall, e_fd, e_fe;
        logic [1:0] fa, fb;
        irs1_d = d.rs1; irs2_d = d.rs2; ird_d = d.rd;
        iuses_rs1_d = d.u1; iuses_rs2_d = d.u2; ird_wr_en_d = d.wr; iload_d = d.ld;
        ipc_src_e = pc; irst = rst;
        #3;
`ifdef RISCV_HAZARD_FWD_EN
        raw = m_e.ld && ((d.u1 && dep(d.rs1, m_e)) || (d.u2 && dep(d.rs2, m_e)));
`else
        raw = (d.u1 && (dep(d.rs1, m_e) || dep(d.rs1, m_m))) ||
              (d.u2 && (dep(d.rs2, m_e) || dep(d.rs2, m_m)));
`endif
        e_stall = !rst && raw && !pc;
        e_fd    = !rst && pc;
        e_fe    = !rst && (pc || raw);
        fa = rst ? 2'b00 : exp_fwd(m_e.rs1);
        fb = rst ? 2'b00 : exp_fwd(m_e.rs2);
        check("stall_f", 32'(ostall_f), 32'(e_stall));
        check("stall_d", 32'(ostall_d), 32'(e_stall));
        check("flush_d", 32'(oflush_d), 32'(e_fd));
        check("flush_e", 32'(oflush_e), 32'(e_fe));
        check("fwd_a", 32'(oforward_a_e), 32'(fa));
        check("fwd_b", 32'(oforward_b_e), 32'(fb));
        check("stall_cnt", 32'(ostall_cnt), rst ? 32'd0 : 32'(m_scnt));
        check("flush_cnt", 32'(oflush_cnt), rst ? 32'd0 : 32'(m_fcnt));
        last_stall = e_stall;
        @(posedge iclk);
        #1;
        if (rst) begin
            m_e = '0; m_m = '0; m_w = '0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (e_stall && m_scnt < CMAX) m_scnt++;
            if (pc && m_fcnt < CMAX) m_fcnt++;
            m_w = m_m;
            m_m = m_e;
            m_e = e_fe ? IDLE : d;
        end
    endtask

    // Present an instruction in D, holding it there while the pipeline is stalled.
    task automatic issue(input instr_t d, input logic pc);
        int n;
        n = 0;
        step(d, pc, 1'b0);
        while (last_stall) begin
            n++;
            if (n > 3) begin
                check("stall_bound", n, 3);
                break;
            end
            step(d, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(IDLE, 1'b0, 1'b1);
        step(IDLE, 1'b0, 1'b1);
    endtask

    initial begin
        int exp_cnt;
        instr_t r;
        @(posedge iclk);
        #1;

        // Reset with busy inputs, then idle.
        step(mk(5, 0, 5, 1, 0, 1, 0), 1'b1, 1'b1);
        step(mk(5, 0, 5, 1, 0, 1, 0), 1'b1, 1'b1);
        step(IDLE, 1'b0, 1'b0);
        check("rst_stall_cnt", 32'(ostall_cnt), 0);
        check("rst_flush_cnt", 32'(oflush_cnt), 0);

        // ALU -> ALU dependency.
        do_reset();
        issue(mk(0, 0, 5, 0, 0, 1, 0), 1'b0);
        issue(mk(5, 0, 0, 1, 0, 0, 0), 1'b0);
`ifdef RISCV_HAZARD_FWD_EN
        check("alu_fwd_a", 32'(oforward_a_e), 32'b10);
        exp_cnt = 0;
`else
        check("alu_fwd_a", 32'(oforward_a_e), 32'b00);
        exp_cnt = 2;
`endif
        issue(IDLE, 1'b0);
        issue(IDLE, 1'b0);
        check("alu_stall_cnt", 32'(ostall_cnt), 32'(exp_cnt));

        // Load-use on rs2.
        do_reset();
        issue(mk(0, 0, 7, 0, 0, 1, 1), 1'b0);
        issue(mk(0, 7, 0, 0, 1, 0, 0), 1'b0);
`ifdef RISCV_HAZARD_FWD_EN
        check("ld_fwd_b", 32'(oforward_b_e), 32'b01);
        exp_cnt = 1;
`else
        check("ld_fwd_b", 32'(oforward_b_e), 32'b00);
        exp_cnt = 2;
`endif
        issue(IDLE, 1'b0);
        check("ld_stall_cnt", 32'(ostall_cnt), 32'(exp_cnt));

        // x0 never creates a dependency.
        do_reset();
        issue(mk(0, 0, 0, 0, 0, 1, 1), 1'b0);
        issue(mk(0, 0, 0, 1, 1, 0, 0), 1'b0);
        issue(IDLE, 1'b0);
        check("x0_stall_cnt", 32'(ostall_cnt), 0);

        // Taken branch in the same cycle as a load-use hazard.
        do_reset();
        issue(mk(0, 0, 7, 0, 0, 1, 1), 1'b0);
        issue(mk(0, 7, 0, 0, 1, 0, 0), 1'b1);
        issue(IDLE, 1'b0);
        check("br_flush_cnt", 32'(oflush_cnt), 1);
        check("br_stall_cnt", 32'(ostall_cnt), 0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(mk(0, 0, 7, 0, 0, 1, 1), 1'b0);
            issue(mk(0, 7, 0, 0, 1, 0, 0), 1'b0);
        end
        issue(IDLE, 1'b0);
        check("sat_stall_cnt", 32'(ostall_cnt), CMAX);
        issue(mk(0, 0, 7, 0, 0, 1, 1), 1'b0);
        issue(mk(0, 7, 0, 0, 1, 0, 0), 1'b0);
        check("sat_stall_hold", 32'(ostall_cnt), CMAX);
        for (int i = 0; i < 20; i++) step(IDLE, 1'b1, 1'b0);
        check("sat_flush_cnt", 32'(oflush_cnt), CMAX);

        // Random traffic on a small register set so dependencies are frequent.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 63) == 0) step(r, 1'($urandom_range(0, 1)), 1'b1);
            else issue(r, ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_hazard.md
# riscv_hazard

Pipeline hazard unit for the 5-stage RISC-V core. It drives the stall, flush and forwarding controls that the control path and datapath consume, including the `iflush_e` input of the control unit. It pipelines its own copies of destination and source register addresses, write enables and load flags through the E/M/W stages, so it is self-contained. It also keeps saturating stall and branch-flush counters for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- iclk  in  1  clock
- irst  in  1  synchronous, active-high reset
- irs1_d  in  5  rs1 of the decode-stage instruction
- irs2_d  in  5  rs2 of the decode-stage instruction
- ird_d  in  5  rd of the decode-stage instruction
- iuses_rs1_d  in  1  decode-stage instruction reads rs1
- iuses_rs2_d  in  1  decode-stage instruction reads rs2
- ird_wr_en_d  in  1  decode-stage instruction writes rd (maindec output)
- iload_d  in  1  decode-stage instruction is a load (result_src[0])
- ipc_src_e  in  1  taken branch/jump resolved in E
- ostall_f  out  1  hold PC
- ostall_d  out  1  hold IF/ID register
- oflush_d  out  1  clear IF/ID register
- oflush_e  out  1  clear ID/EX register (drives the control unit's `iflush_e`)
- oforward_a_e  out  2  ALU operand A select: 00 regfile, 01 W result, 10 M ALU result
- oforward_b_e  out  2  ALU operand B select, same encoding
- ostall_cnt  out  CNT_W  cycles with ostall_d=1
- oflush_cnt  out  CNT_W  cycles with ipc_src_e=1

## Operation
- **Internal registers.**
  - E stage: rs1_e, rs2_e, rd_e, wr_en_e, load_e.
  - M stage: rd_m, wr_en_m.
  - W stage: rd_w, wr_en_w.
  - Plus the two counters.
- **D→E transfer.**
  - Loads the D inputs each cycle.
  - Loads all zeros when oflush_e=1 or irst=1.
  - D inputs are not latched on ostall_d; the external IF/ID register holds them.
- **E→M and M→W transfer.** Always advance; zero on irst.
- **Match rule.** A source "matches" a stage when:
  - the addresses are equal,
  - the address is nonzero, and
  - that stage's wr_en=1.
  - x0 never matches.
- **lwstall.** Asserted when load_e=1 and rd_e matches (irs1_d with iuses_rs1_d) or (irs2_d with iuses_rs2_d).
- **ostall_f / ostall_d.** Equal to lwstall & ~ipc_src_e. A taken branch overrides the stall, because the D instruction is wrong-path and the PC must load the target.
- **oflush_d.** Equal to ipc_src_e.
- **oflush_e.** Equal to ipc_src_e | lwstall.
- **Forwarding (rs1_e → oforward_a_e, rs2_e → oforward_b_e).**
  - 10 if the source matches rd_m.
  - Else 01 if it matches rd_w.
  - Else 00.
  - M has priority over W.
- **Register file.** Writes in the first half-cycle, so a W→D dependency needs neither a stall nor forwarding in D.
- **Counters.**
  - ostall_cnt increments on cycles where ostall_d=1.
  - oflush_cnt increments on cycles where ipc_src_e=1.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- All stall, flush and forward outputs are combinational from current inputs and registered state. Zero-cycle latency.
- State updates on the rising edge of iclk.
- Reset:
  - While irst=1, all outputs are forced to 0 regardless of inputs.
  - After the first reset edge, all internal registers and both counters are 0.
- A load-use stall lasts exactly one cycle. The next cycle, the load is in M and a bubble is in E, so lwstall deasserts.
- The consumer then sees forwarding 01 when it reaches E (load in W).
- Simultaneous ipc_src_e and lwstall: stall 0, oflush_d=1, oflush_e=1. oflush_cnt increments; ostall_cnt does not.
- irst asserted mid-stall: the stall drops in the same cycle, and the pipeline copies clear on the edge.

## Configuration
- **RISCV_HAZARD_FWD_EN defined:** forwarding and stalling exactly as above.
- **RISCV_HAZARD_FWD_EN undefined:**
  - oforward_a_e and oforward_b_e are tied to 00.
  - lwstall is replaced by rawstall: an used decode source matches rd_e or rd_m (load or not).
  - ostall_f, ostall_d and oflush_e use rawstall in place of lwstall; the ~ipc_src_e override is unchanged.
  - W matches never stall.

## Test plan
- **Reset.** Hold irst=1 for 2 cycles with ipc_src_e=1 and irs1_d=ird_d=5 → every output is 0. After release with idle inputs, both counters read 0.
- **ALU→ALU forward.**
  - Stimulus: D rd=5 (wr_en=1, load=0), then D rs1=5 (uses=1), then idle.
  - With forwarding: no stall; in the consumer's E cycle, oforward_a_e=10.
  - Without the macro: ostall_d=1 for 2 cycles, ostall_cnt=2.
- **Load-use.**
  - Stimulus: D load rd=7, then D rs2=7 (uses=1).
  - Expect one cycle of ostall_f=ostall_d=oflush_e=1.
  - When the consumer is in E, oforward_b_e=01. ostall_cnt=1.
- **x0 suppression.** Load with rd=0 followed by rs1=0, rs2=0 → no stall, forwards stay 00.
- **Branch over load-use.** Create the lwstall condition with ipc_src_e=1 in the same cycle → ostall_f=0, ostall_d=0, oflush_d=1, oflush_e=1. oflush_cnt=1, ostall_cnt=0.
- **Saturation.** With CNT_W=4, drive 20 load-use stalls → ostall_cnt=15 and it stays 15.
